// File: rtl/cnn_layer_accel_awe_input_sched.sv
// Input scheduler for the AWE octo BRAM controllers.
// Shares one FWFT input FIFO stream between C_NUM_AWE controllers. For each map
// it pulses awe_new_map to every enabled AWE. It then broadcasts cfg_seq_words
// sequencer words, and a word is popped only once every enabled AWE has taken it.
// After that it deals cfg_num_rows pixel rows round-robin, one whole row per AWE.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, cfg_*        map start request and per-map configuration
//   busy, done          map in progress / one-cycle completion pulse
//   in_*                FIFO head (valid, data, row-last) and pop strobe
//   awe_*               per-AWE new-map/valid strobes, shared tags and data,
//                       and the per-AWE accept strobes coming back
module cnn_layer_accel_awe_input_sched #(
  parameter int unsigned C_NUM_AWE       = 4,
  parameter int unsigned C_DATA_WIDTH    = 64,
  parameter int unsigned C_SEQ_CNT_WIDTH = 12,
  parameter int unsigned C_ROW_CNT_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [C_NUM_AWE-1:0]       cfg_awe_en,
  input  logic [C_SEQ_CNT_WIDTH-1:0] cfg_seq_words,
  input  logic [C_ROW_CNT_WIDTH-1:0] cfg_num_rows,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  input  logic [C_DATA_WIDTH-1:0]    in_data,
  input  logic                       in_last,
  output logic                       in_rden,
  output logic [C_NUM_AWE-1:0]       awe_new_map,
  output logic [C_NUM_AWE-1:0]       awe_datain_valid,
  output logic                       awe_seq_tag,
  output logic                       awe_pixel_tag,
  output logic [C_DATA_WIDTH-1:0]    awe_data,
  input  logic [C_NUM_AWE-1:0]       awe_seq_rdy,
  input  logic [C_NUM_AWE-1:0]       awe_pixel_rdy
);

  localparam int unsigned AW = (C_NUM_AWE > 1) ? $clog2(C_NUM_AWE) : 1;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_NEW_MAP = 5'b00010,
    ST_SEQ     = 5'b00100,
    ST_PIXEL   = 5'b01000,
    ST_DONE    = 5'b10000
  } state_t;

  state_t                     state_q, state_d;
  logic [C_NUM_AWE-1:0]       en_q, en_d;
  logic [C_SEQ_CNT_WIDTH-1:0] seq_words_q, seq_words_d;
  logic [C_ROW_CNT_WIDTH-1:0] num_rows_q, num_rows_d;
  logic [C_SEQ_CNT_WIDTH-1:0] seq_cnt_q, seq_cnt_d;
  logic [C_ROW_CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [C_NUM_AWE-1:0]       acc_q, acc_d;
  logic [AW-1:0]              cur_awe_q, cur_awe_d;
  logic                       busy_q, done_q;
  logic [C_NUM_AWE-1:0]       new_map_q;

  logic [AW-1:0]              lowest_awe;
  logic [AW-1:0]              next_awe;
  logic                       next_found;
  logic [C_NUM_AWE-1:0]       seq_take;

  assign busy        = busy_q;
  assign done        = done_q;
  assign awe_new_map = new_map_q;
  assign awe_data    = in_data;

  // Scanning downward leaves the lowest enabled index as the final assignment.
  always_comb begin
    lowest_awe = '0;
    for (int unsigned i = C_NUM_AWE; i > 0; i--) begin
      if (en_q[AW'(i - 1)]) lowest_awe = AW'(i - 1);
    end
  end

  // First enabled index after cur_awe, wrapping; with one AWE enabled this
  // lands back on cur_awe itself at offset C_NUM_AWE.
  always_comb begin
    next_awe   = cur_awe_q;
    next_found = 1'b0;
    for (int unsigned k = 1; k <= C_NUM_AWE; k++) begin
      if (!next_found && en_q[AW'((32'(cur_awe_q) + k) % C_NUM_AWE)]) begin
        next_awe   = AW'((32'(cur_awe_q) + k) % C_NUM_AWE);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    en_d             = en_q;
    seq_words_d      = seq_words_q;
    num_rows_d       = num_rows_q;
    seq_cnt_d        = seq_cnt_q;
    row_cnt_d        = row_cnt_q;
    acc_d            = acc_q;
    cur_awe_d        = cur_awe_q;
    seq_take         = '0;
    in_rden          = 1'b0;
    awe_datain_valid = '0;
    awe_seq_tag      = 1'b0;
    awe_pixel_tag    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && (cfg_awe_en != '0)) begin
          en_d        = cfg_awe_en;
          seq_words_d = cfg_seq_words;
          num_rows_d  = cfg_num_rows;
          state_d     = ST_NEW_MAP;
        end
      end
      ST_NEW_MAP: begin
        seq_cnt_d = '0;
        row_cnt_d = '0;
        acc_d     = '0;
        cur_awe_d = lowest_awe;
        // A map with no sequencer words and no rows has nothing to deliver.
        if (seq_words_q != '0)     state_d = ST_SEQ;
        else if (num_rows_q != '0) state_d = ST_PIXEL;
        else                       state_d = ST_DONE;
      end
      ST_SEQ: begin
        awe_seq_tag      = 1'b1;
        awe_datain_valid = {C_NUM_AWE{in_valid}} & en_q & ~acc_q;
        seq_take         = awe_seq_rdy & awe_datain_valid;
        if (in_valid && ((acc_q | seq_take) == en_q)) begin
          in_rden   = 1'b1;
          acc_d     = '0;
          seq_cnt_d = seq_cnt_q + 1'b1;
          if (seq_cnt_q == seq_words_q - C_SEQ_CNT_WIDTH'(1)) begin
            state_d = (num_rows_q == '0) ? ST_DONE : ST_PIXEL;
          end
        end else begin
          acc_d = acc_q | seq_take;
        end
      end
      ST_PIXEL: begin
        awe_pixel_tag               = 1'b1;
        awe_datain_valid[cur_awe_q] = in_valid;
        if (in_valid && awe_pixel_rdy[cur_awe_q]) begin
          in_rden = 1'b1;
          if (in_last) begin
            row_cnt_d = row_cnt_q + 1'b1;
            cur_awe_d = next_awe;
            if (row_cnt_q == num_rows_q - C_ROW_CNT_WIDTH'(1)) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      en_q        <= '0;
      seq_words_q <= '0;
      num_rows_q  <= '0;
      seq_cnt_q   <= '0;
      row_cnt_q   <= '0;
      acc_q       <= '0;
      cur_awe_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      new_map_q   <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      seq_words_q <= seq_words_d;
      num_rows_q  <= num_rows_d;
      seq_cnt_q   <= seq_cnt_d;
      row_cnt_q   <= row_cnt_d;
      acc_q       <= acc_d;
      cur_awe_q   <= cur_awe_d;
      // Registered from next state so each flag lines up with its state.
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      new_map_q   <= (state_d == ST_NEW_MAP) ? en_d : '0;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_awe_input_sched.sv
module tb_cnn_layer_accel_awe_input_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  cfg_awe_en;
  logic [11:0] cfg_seq_words;
  logic [9:0]  cfg_num_rows;
  logic        busy, done;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_last;
  logic        in_rden;
  logic [3:0]  awe_new_map, awe_datain_valid;
  logic        awe_seq_tag, awe_pixel_tag;
  logic [63:0] awe_data;
  logic [3:0]  awe_seq_rdy, awe_pixel_rdy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  cnn_layer_accel_awe_input_sched #(
    .C_NUM_AWE(4), .C_DATA_WIDTH(64), .C_SEQ_CNT_WIDTH(12), .C_ROW_CNT_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_awe_en(cfg_awe_en),
    .cfg_seq_words(cfg_seq_words), .cfg_num_rows(cfg_num_rows),
    .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_rden(in_rden), .awe_new_map(awe_new_map),
    .awe_datain_valid(awe_datain_valid), .awe_seq_tag(awe_seq_tag),
    .awe_pixel_tag(awe_pixel_tag), .awe_data(awe_data),
    .awe_seq_rdy(awe_seq_rdy), .awe_pixel_rdy(awe_pixel_rdy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic start_map(input logic [3:0] en, input logic [11:0] sw, input logic [9:0] nr);
    cfg_awe_en = en; cfg_seq_words = sw; cfg_num_rows = nr;
    start = 1'b1; in_valid = 1'b1; awe_seq_rdy = 4'hF; awe_pixel_rdy = 4'hF;
    #1;
    chk("idle_rden", in_rden, 1'b0);
    chk("idle_valid", awe_datain_valid, 4'h0);
    adv();
    start = 1'b0;
    #1;
    chk("new_map", awe_new_map, en);
    chk("nm_busy", busy, 1'b1);
    chk("nm_rden", in_rden, 1'b0);
    chk("nm_valid", awe_datain_valid, 4'h0);
    adv();
  endtask

  task automatic seq_word(input logic [3:0] rdy, input logic [3:0] exp_valid, input logic exp_rden);
    in_valid = 1'b1; in_last = 1'b0; awe_seq_rdy = rdy;
    in_data = {$urandom, $urandom};
    #1;
    chk("seq_tag", awe_seq_tag, 1'b1);
    chk("seq_valid", awe_datain_valid, exp_valid);
    chk("seq_rden", in_rden, exp_rden);
    chk("seq_data", awe_data, in_data);
    chk("seq_new_map", awe_new_map, 4'h0);
    adv();
  endtask

  task automatic pix(input int cur, input logic [3:0] rdy, input logic last, input logic exp_rden);
    logic [3:0] exp_valid;
    exp_valid = 4'b0001 << cur;
    in_valid = 1'b1; in_last = last; awe_pixel_rdy = rdy;
    in_data = {$urandom, $urandom};
    #1;
    chk("pix_tag", awe_pixel_tag, 1'b1);
    chk("pix_seq_tag", awe_seq_tag, 1'b0);
    chk("pix_valid", awe_datain_valid, exp_valid);
    chk("pix_rden", in_rden, exp_rden);
    adv();
  endtask

  task automatic stall(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("stall_rden", in_rden, 1'b0);
      chk("stall_valid", awe_datain_valid, 4'h0);
      adv();
    end
  endtask

  task automatic expect_done();
    in_valid = 1'b0;
    #1;
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    chk("done_rden", in_rden, 1'b0);
    adv();
    chk("done_clear", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_awe_en = '0; cfg_seq_words = '0; cfg_num_rows = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; awe_seq_rdy = '0; awe_pixel_rdy = '0;
    adv();
    adv();
    in_valid = 1'b1; awe_seq_rdy = 4'hF; awe_pixel_rdy = 4'hF;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_new_map", awe_new_map, 4'h0);
    chk("rst_rden", in_rden, 1'b0);
    chk("rst_valid", awe_datain_valid, 4'h0);
    chk("rst_tags", {awe_seq_tag, awe_pixel_tag}, 2'b00);
    rst = 1'b0;
    adv();

    // Full map, all AWEs enabled, 3 sequencer words, 4 rows of 2 words
    start_map(4'hF, 12'd3, 10'd4);
    for (int i = 0; i < 3; i++) seq_word(4'hF, 4'hF, 1'b1);
    for (int r = 0; r < 4; r++) begin
      pix(r, 4'hF, 1'b0, 1'b1);
      pix(r, 4'hF, 1'b1, 1'b1);
    end
    expect_done();

    // Staggered sequencer accepts on mask 0101
    start_map(4'b0101, 12'd1, 10'd1);
    seq_word(4'b0001, 4'b0101, 1'b0);
    seq_word(4'b0000, 4'b0100, 1'b0);
    seq_word(4'b0010, 4'b0100, 1'b0);
    seq_word(4'b0100, 4'b0100, 1'b1);
    pix(0, 4'b0001, 1'b1, 1'b1);
    expect_done();

    // Sparse mask 1010, no sequencer words, 5 rows, stray strobes, stall
    start_map(4'b1010, 12'd0, 10'd5);
    pix(1, 4'b0001, 1'b0, 1'b0);
    pix(1, 4'b0010, 1'b1, 1'b1);
    pix(3, 4'b0001, 1'b0, 1'b0);
    pix(3, 4'b1000, 1'b1, 1'b1);
    pix(1, 4'b0010, 1'b0, 1'b1);
    stall(10);
    start = 1'b1; cfg_awe_en = 4'hF;
    pix(1, 4'b0010, 1'b1, 1'b1);
    start = 1'b0;
    pix(3, 4'hF, 1'b1, 1'b1);
    pix(1, 4'b0010, 1'b1, 1'b1);
    in_valid = 1'b0; cfg_awe_en = 4'hF; start = 1'b1;
    #1;
    chk("sparse_done", done, 1'b1);
    adv();
    start = 1'b0;
    chk("done_start_busy", busy, 1'b0);
    chk("done_start_new_map", awe_new_map, 4'h0);
    chk("done_start_done", done, 1'b0);
    adv();
    chk("done_start_idle", busy, 1'b0);

    // Start with empty mask is ignored
    cfg_awe_en = 4'h0; cfg_seq_words = 12'd1; cfg_num_rows = 10'd1; start = 1'b1;
    adv();
    start = 1'b0;
    chk("en0_busy", busy, 1'b0);
    chk("en0_new_map", awe_new_map, 4'h0);

    // No rows: done right after sequencer words
    start_map(4'b0010, 12'd2, 10'd0);
    seq_word(4'b0010, 4'b0010, 1'b1);
    seq_word(4'b0010, 4'b0010, 1'b1);
    expect_done();

    // Reset mid-map during row 2, then a fresh map
    start_map(4'b0110, 12'd0, 10'd4);
    pix(1, 4'b0110, 1'b1, 1'b1);
    pix(2, 4'b0110, 1'b1, 1'b1);
    pix(1, 4'b0010, 1'b0, 1'b1);
    rst = 1'b1; in_valid = 1'b1; awe_pixel_rdy = 4'hF;
    adv();
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_new_map", awe_new_map, 4'h0);
    chk("mid_rst_rden", in_rden, 1'b0);
    chk("mid_rst_valid", awe_datain_valid, 4'h0);
    chk("mid_rst_tags", {awe_seq_tag, awe_pixel_tag}, 2'b00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      adv();
      chk("mid_rst_no_done", done, 1'b0);
    end
    start_map(4'b0110, 12'd1, 10'd2);
    seq_word(4'b0110, 4'b0110, 1'b1);
    pix(1, 4'b0110, 1'b1, 1'b1);
    pix(2, 4'b0110, 1'b1, 1'b1);
    expect_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
